// File: rtl/pretrade_risk_gate.sv
// Pre-trade risk gate: buffers CPU orders in a small FIFO, checks each against the trading
// limit and either forwards it on a valid/ready port or drops and counts it.
module pretrade_risk_gate #(
    parameter int unsigned ID_W       = 5,
    parameter int unsigned AMT_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ID_W-1:0]  in_client_id,
    input  logic [AMT_W-1:0] in_amount,
    input  logic             max_load,
    input  logic [31:0]      max_in,
    input  logic [31:0]      cancelled_total,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ID_W-1:0]  out_client_id,
    output logic [AMT_W-1:0] out_amount,
    output logic [AMT_W-1:0] accumulated_orders,
    output logic [31:0]      max_to_trade,
    output logic             reject_pulse,
    output logic [15:0]      rejected_count,
    output logic             busy
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned ENT_W = ID_W + AMT_W;
    localparam int unsigned EXP_W = AMT_W + 2;
    localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] CntOne  = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {StIdle, StCheck, StSend, StReject} state_e;

    state_e state_q, state_d;

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0] head;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             in_ready_q;
    logic             head_avail_q;
    logic             push, pop;

    logic [ID_W-1:0]  hold_id_q;
    logic [AMT_W-1:0] hold_amt_q;
    logic [AMT_W-1:0] acc_q, acc_sat;
    logic [AMT_W:0]   acc_sum;
    logic [AMT_W-1:0] limit_q;
    logic [15:0]      rej_cnt_q;
    logic [EXP_W-1:0] exp_val;
    logic             check_pass;
    logic             unused_hi;

    assign push = in_valid & in_ready_q;
    assign pop  = (state_q == StIdle) & head_avail_q;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntOne;
        end else if (pop && !push) begin
            count_d = count_q - CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_client_id, in_amount};
        end
    end

    // head_avail_q lags occupancy by one cycle; safe because IDLE is revisited no sooner
    // than two cycles after a pop, and it sets the accept-to-out latency to three edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b0;
            head_avail_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q      <= count_d;
            in_ready_q   <= (count_d != FullCnt);
            head_avail_q <= (count_q != '0);
        end
    end

    // Signed 18-bit view so a large cancelled total can drive the exposure negative.
    assign exp_val    = {2'b00, acc_q} + {2'b00, hold_amt_q}
                      - {2'b00, cancelled_total[AMT_W-1:0]};
    assign check_pass = $signed(exp_val) < $signed({2'b00, limit_q});

    assign acc_sum = {1'b0, acc_q} + {1'b0, hold_amt_q};
    assign acc_sat = acc_sum[AMT_W] ? '1 : acc_sum[AMT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (head_avail_q) state_d = StCheck;
            StCheck:  state_d = check_pass ? StSend : StReject;
            StSend:   if (out_ready) state_d = StIdle;
            StReject: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid    = 1'b0;
        reject_pulse = 1'b0;
        unique case (state_q)
            StSend:   out_valid    = 1'b1;
            StReject: reject_pulse = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_id_q  <= '0;
            hold_amt_q <= '0;
            acc_q      <= '0;
            limit_q    <= '0;
            rej_cnt_q  <= '0;
        end else begin
            if (pop) begin
                hold_id_q  <= head[ENT_W-1:AMT_W];
                hold_amt_q <= head[AMT_W-1:0];
            end
            if (max_load) begin
                limit_q <= max_in[AMT_W-1:0];
            end
            if (state_q == StSend && out_ready) begin
                acc_q <= acc_sat;
            end
            if (state_q == StReject && rej_cnt_q != 16'hFFFF) begin
                rej_cnt_q <= rej_cnt_q + 16'd1;
            end
        end
    end

    assign in_ready           = in_ready_q;
    assign out_client_id      = hold_id_q;
    assign out_amount         = hold_amt_q;
    assign accumulated_orders = acc_q;
    assign max_to_trade       = 32'(limit_q);
    assign rejected_count     = rej_cnt_q;
    assign busy               = (state_q != StIdle) | (count_q != '0);

    assign unused_hi = ^{max_in[31:AMT_W], cancelled_total[31:AMT_W]};

endmodule
